// File: rtl/bcd_display_pkg.sv
// Shared constants and types for the multiplexed BCD seven-segment scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-low (common-anode display).
package bcd_display_pkg;

  localparam int unsigned DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {D0, D1, D2, D3} digit_idx_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment pattern; codes 10-15 show a dash.
module bcd_to_seg7
  import bcd_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// 4-digit multiplexed seven-segment scanner with frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100000000,
  parameter int unsigned DIGIT_HZ = 1000
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        bcd_valid,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int unsigned DIV   = CLK_HZ / DIGIT_HZ;
  localparam int unsigned DIV_W = (DIV < 2) ? 1 : $clog2(DIV);

  generate
    if (DIV < 2) begin : g_div_check
      $error("bcd_display_scanner: CLK_HZ/DIGIT_HZ must be at least 2");
    end
  endgenerate

  logic [DIV_W-1:0] r_div;
  digit_idx_t       r_idx;
  logic [15:0]      r_disp_bcd;
  logic [3:0]       r_disp_dp;
  logic [15:0]      r_pend_bcd;
  logic [3:0]       r_pend_dp;
  logic             r_pend_flag;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic [3:0]       r_an;
  logic             r_frame_tick;

  logic             w_tick;
  logic             w_boundary;
  logic [3:0]       w_nib;
  logic [6:0]       w_seg;
  logic             w_blank;

  assign w_tick     = (r_div == DIV_W'(DIV - 1));
  assign w_boundary = w_tick && (r_idx == D3);
  assign w_nib      = r_disp_bcd[{r_idx, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .i_bcd (w_nib),
    .o_seg (w_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // w_lz[i]: digit i and every higher digit are zero with no dp lit
  logic [DIGITS-1:0] w_lz;
  always_comb begin
    w_lz = '0;
    w_lz[DIGITS-1] = (r_disp_bcd[15:12] == 4'd0) && !r_disp_dp[DIGITS-1];
    for (int unsigned i = 1; i < DIGITS; i++) begin
      w_lz[DIGITS-1-i] = w_lz[DIGITS-i]
                         && (r_disp_bcd[4*(DIGITS-1-i) +: 4] == 4'd0)
                         && !r_disp_dp[DIGITS-1-i];
    end
  end
  assign w_blank = (r_idx != D0) && w_lz[r_idx];
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div        <= '0;
      r_idx        <= D0;
      r_disp_bcd   <= '0;
      r_disp_dp    <= '0;
      r_pend_bcd   <= '0;
      r_pend_dp    <= '0;
      r_pend_flag  <= 1'b0;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_an         <= '1;
      r_frame_tick <= 1'b0;
    end else begin
      r_div        <= w_tick ? '0 : r_div + 1'b1;
      r_frame_tick <= w_boundary;
      if (w_tick) begin
        r_idx <= digit_idx_t'(r_idx + 2'd1);
      end

      // A strobe landing on the boundary edge bypasses the pending buffer.
      if (w_boundary && bcd_valid) begin
        r_disp_bcd  <= bcd_in;
        r_disp_dp   <= dp_in;
        r_pend_flag <= 1'b0;
      end else if (w_boundary && r_pend_flag) begin
        r_disp_bcd  <= r_pend_bcd;
        r_disp_dp   <= r_pend_dp;
        r_pend_flag <= 1'b0;
      end else if (bcd_valid) begin
        r_pend_bcd  <= bcd_in;
        r_pend_dp   <= dp_in;
        r_pend_flag <= 1'b1;
      end

      if (w_blank) begin
        r_an  <= '1;
        r_seg <= SEG_BLANK;
        r_dp  <= 1'b1;
      end else begin
        r_an        <= '1;
        r_an[r_idx] <= 1'b0;
        r_seg       <= w_seg;
        r_dp        <= ~r_disp_dp[r_idx];
      end
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner (CLK_HZ=16, DIGIT_HZ=4, so 4 clocks per digit).
// Expected {an,seg,dp,frame_tick} words are queued as stimulus is driven and popped at each negedge.
module tb_bcd_display_scanner;

  logic        clk;
  logic        rst;
  logic [15:0] bcd_in;
  logic        bcd_valid;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [12:0] q[$];
  logic [15:0] cur_b;
  logic [3:0]  cur_d;

  bcd_display_scanner #(
    .CLK_HZ   (16),
    .DIGIT_HZ (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .bcd_valid  (bcd_valid),
    .dp_in      (dp_in),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [12:0] exp_out(input logic [15:0] b, input logic [3:0] d,
                                          input int unsigned dig, input logic tick);
    logic [3:0] a;
    logic       blank;
    a = 4'b1111;
    a[dig] = 1'b0;
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (dig != 0) begin
      blank = 1'b1;
      for (int unsigned j = dig; j < 4; j++)
        if (b[4*j +: 4] != 4'd0 || d[j]) blank = 1'b0;
    end
`endif
    if (blank) return {4'b1111, 7'h7F, 1'b1, tick};
    return {a, seg_of(b[4*dig +: 4]), ~d[dig], tick};
  endfunction

  task automatic compare(input logic [12:0] e, input string tag);
    logic [12:0] obs;
    obs = {an, seg, dp, frame_tick};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed an=%b seg=%b dp=%b ft=%b, expected an=%b seg=%b dp=%b ft=%b",
             tag, obs[12:9], obs[8:2], obs[1], obs[0], e[12:9], e[8:2], e[1], e[0]);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] b, input logic [3:0] d,
                      input logic [12:0] e, input string tag);
    q.push_back(e);
    bcd_valid = v;
    bcd_in    = b;
    dp_in     = d;
    @(posedge clk);
    #1 bcd_valid = 1'b0;
    @(negedge clk);
    compare(q.pop_front(), tag);
  endtask

  // One scan frame (or its first ncyc cycles) showing sb/sd, with up to two strobes at cycle slots sa1/sa2.
  task automatic run_frame(input logic [15:0] sb, input logic [3:0] sd,
                           input int unsigned sa1, input logic [15:0] b1, input logic [3:0] d1,
                           input int unsigned sa2, input logic [15:0] b2, input logic [3:0] d2,
                           input string name, input int unsigned ncyc);
    for (int unsigned c = 1; c <= ncyc; c++) begin
      if (c == sa2)
        step(1'b1, b2, d2, exp_out(sb, sd, (c - 1) / 4, c == 16), $sformatf("%s_c%0d", name, c));
      else if (c == sa1)
        step(1'b1, b1, d1, exp_out(sb, sd, (c - 1) / 4, c == 16), $sformatf("%s_c%0d", name, c));
      else
        step(1'b0, 16'h0000, 4'h0, exp_out(sb, sd, (c - 1) / 4, c == 16), $sformatf("%s_c%0d", name, c));
    end
  endtask

  initial begin
    rst       = 1'b0;
    bcd_in    = '0;
    bcd_valid = 1'b0;
    dp_in     = '0;
    #12;
    compare({4'b1111, 7'h7F, 1'b1, 1'b0}, "reset_state");
    @(negedge clk);
    rst = 1'b1;

    run_frame(16'h0000, 4'h0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, "idle", 16);
    run_frame(16'h0000, 4'h0, 6, 16'h1234, 4'b0100, 0, 16'h0, 4'h0, "cap1234", 16);
    run_frame(16'h1234, 4'b0100, 3, 16'h1111, 4'h0, 9, 16'h9876, 4'h0, "show1234", 16);
    run_frame(16'h9876, 4'h0, 16, 16'h0005, 4'h0, 0, 16'h0, 4'h0, "show9876", 16);
    run_frame(16'h0005, 4'h0, 2, 16'h00A7, 4'h0, 0, 16'h0, 4'h0, "bypass5", 16);
    cur_b = 16'h00A7;
    cur_d = 4'h0;
`ifdef LEADING_ZERO_BLANK_EN
    run_frame(16'h00A7, 4'h0, 5, 16'h0042, 4'h0, 0, 16'h0, 4'h0, "dashA7", 16);
    run_frame(16'h0042, 4'h0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, "lzb42", 16);
    cur_b = 16'h0042;
`else
    run_frame(16'h00A7, 4'h0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, "dashA7", 16);
`endif

    // Queue a pending value mid-frame, then reset asynchronously away from any clock edge.
    run_frame(cur_b, cur_d, 3, 16'h8888, 4'hF, 0, 16'h0, 4'h0, "prereset", 5);
    #1 rst = 1'b0;
    #1 compare({4'b1111, 7'h7F, 1'b1, 1'b0}, "async_reset");
    @(negedge clk);
    compare({4'b1111, 7'h7F, 1'b1, 1'b0}, "held_reset");
    rst = 1'b1;
    run_frame(16'h0000, 4'h0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, "post_reset", 16);
    run_frame(16'h0000, 4'h0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0, "pend_lost", 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Consumes the 16-bit packed BCD word from the binary-to-BCD stage and drives a 4-digit, common-anode, multiplexed seven-segment display.
- Time-multiplexes digits with a parameterised refresh divider.
- New values are double-buffered and applied only at frame boundaries, so a digit never tears mid-scan.
- Sits between the BCD converter and the board display pins.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- DIGIT_HZ, 1000, per-digit dwell rate in Hz. DIV = CLK_HZ/DIGIT_HZ; elaboration error if DIV < 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- bcd_in  in  16  packed BCD: [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands.
- bcd_valid  in  1  single-cycle strobe; captures bcd_in and dp_in.
- dp_in  in  4  decimal point request per digit, 1 = lit; bit i maps to digit i.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  4  digit enables, active-low; an[0] = ones digit.
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

Behaviour:
- Reset (rst=0, async): an=4'b1111, seg=7'h7F, dp=1, frame_tick=0. Divider=0, digit index=0, display and pending registers=0, pending flag=0.
- Reset mid-scan: outputs blank immediately without waiting for a clock edge. Any pending value is discarded.
- Divider: counts 0..DIV-1 and wraps. The terminal count produces an internal tick.
- Scan state (2-bit index, states D0→D1→D2→D3→D0): advances only on tick.
- Frame boundary: the tick that moves D3→D0.
  - frame_tick is registered and pulses in the cycle after the boundary edge.
- Capture: on bcd_valid, {bcd_in, dp_in} is written to the pending register and the pending flag is set.
  - Multiple strobes within one frame: last one wins.
- Apply: at the frame boundary, if the pending flag is set, pending → display register and the flag clears.
  - bcd_valid coincident with the boundary edge: the incoming value bypasses and is applied at that same boundary; the flag stays clear.
- Outputs are registered from the current index and display register, so there is 1-cycle latency from an index change to the pins.
  - Exactly one an bit is low at any time after the first post-reset edge.
  - The first post-reset edge gives an=4'b1110 showing digit 0.
- Decode, nibble → seg:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - 10–15 (illegal BCD) = dash, 0111111
- dp = ~display_dp[index].
- No ghosting handling is required beyond the registered, glitch-free an.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits 3..1 are blanked (an bit held high, seg=7'h7F, dp=1) while the digit and all higher digits are 0 and the digit's own dp request is 0.
  - Blanking stops at the first nonzero nibble, dash, or lit dp.
  - Digit 0 is never blanked.
  - The blank decision uses the display register only.
- Undefined: all four digits are always shown, including zeros.

Decomposition:
- Package bcd_display_pkg holds:
  - segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - digit index typedef (2-bit);
  - DIGITS=4.
- Sub-module bcd_to_seg7: purely combinational nibble → 7-bit pattern. Instantiated once and fed from a mux on the digit index.

Test Plan (CLK_HZ=16, DIGIT_HZ=4 → DIV=4):
1. Reset release, no strobe → an cycles 1110,1101,1011,0111, 4 clocks each; seg=1000000 throughout; frame_tick pulses every 16 clocks.
2. bcd_valid with bcd_in=16'h1234, dp_in=4'b0100 mid-frame → display unchanged until the next boundary; then digit0=0011001 (4), digit1=0110000, digit2=0100100 with dp=0, digit3=1111001.
3. Two strobes in one frame (16'h1111 then 16'h9876) → only 9876 is ever displayed; 1111 never appears.
4. Strobe coincident with the boundary edge, bcd_in=16'h0005 → 5 is shown on digit 0 in that same frame.
5. bcd_in=16'h00A7 → digit1 shows dash 0111111; digit0 shows 1111000. With LEADING_ZERO_BLANK_EN and 16'h0042: an[3:2] never go low; digits 1 and 0 show 4 and 2.
6. rst driven low mid-digit with no clock → an=1111 and seg=7F immediately. After release the scan restarts at D0 showing 0; a prior pending value is lost.
